// File: rtl/vga_timing_pkg.sv
// Shared SVGA 800x600@60 timing constants and a small raster-window helper.
package vga_timing_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FP      = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BP      = 88;
  localparam int V_VISIBLE = 600;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BP      = 23;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_FIRST = H_VISIBLE + H_FP;
  localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
  localparam int V_SYNC_FIRST = V_VISIBLE + V_FP;
  localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);

  localparam logic SYNC_POL = 1'b1;

  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping raster axis counter with terminal-count, zero,
// active-window and sync-window decodes of the live count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W          = 11,
  parameter int TOTAL      = 1056,
  parameter int ACTIVE     = 800,
  parameter int SYNC_FIRST = 840,
  parameter int SYNC_LAST  = 967
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o,
  output logic         zero_o,
  output logic         active_o,
  output logic         sync_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_o    = cnt_q;
  assign tc_o     = (cnt_q == W'(TOTAL - 1));
  assign zero_o   = (cnt_q == {W{1'b0}});
  assign active_o = in_window(32'(cnt_q), 0, ACTIVE - 1);
  assign sync_o   = in_window(32'(cnt_q), SYNC_FIRST, SYNC_LAST);

  // Next count: hold when disabled, wrap at terminal count, else increment.
  always_comb begin
    if (!en_i) begin
      cnt_d = cnt_q;
    end else if (tc_o) begin
      cnt_d = {W{1'b0}};
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_800x600.sv
// SVGA 800x600@60 raster timing generator: registered sync/DE/coordinates
// lagging a live fetch address by one clock for a synchronous pixel source.
module vga_timing_800x600 #(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP      = vga_timing_pkg::V_FP,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BP      = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic                               clk_in,
  input  logic                               rst_n,
  input  logic                               en,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               de,
  output logic [vga_timing_pkg::H_CNT_W-1:0] pix_x,
  output logic [vga_timing_pkg::V_CNT_W-1:0] pix_y,
  output logic                               frame_start,
  output logic                               line_start,
  output logic                               fetch_req,
  output logic [9:0]                         fetch_x,
  output logic [vga_timing_pkg::V_CNT_W-1:0] fetch_y
);

  localparam int HW     = vga_timing_pkg::H_CNT_W;
  localparam int VW     = vga_timing_pkg::V_CNT_W;
  localparam int H_TOT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_cnt_s;
  logic [VW-1:0] v_cnt_s;
  logic h_tc_s, h_zero_s, h_act_s, h_sync_s;
  logic v_tc_unused_s, v_zero_s, v_act_s, v_sync_s;
  logic v_en_s;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [HW-1:0] pix_x_q, pix_x_d;
  logic [VW-1:0] pix_y_q, pix_y_d;
  logic          frame_start_q, frame_start_d;
  logic          line_start_q, line_start_d;

  assign v_en_s = en & h_tc_s;

  vga_axis_counter #(
    .W(HW), .TOTAL(H_TOT), .ACTIVE(H_VISIBLE),
    .SYNC_FIRST(H_VISIBLE + H_FP), .SYNC_LAST(H_VISIBLE + H_FP + H_SYNC - 1)
  ) u_h_axis (
    .clk_i(clk_in), .rst_ni(rst_n), .en_i(en),
    .cnt_o(h_cnt_s), .tc_o(h_tc_s), .zero_o(h_zero_s),
    .active_o(h_act_s), .sync_o(h_sync_s)
  );

  vga_axis_counter #(
    .W(VW), .TOTAL(V_TOT), .ACTIVE(V_VISIBLE),
    .SYNC_FIRST(V_VISIBLE + V_FP), .SYNC_LAST(V_VISIBLE + V_FP + V_SYNC - 1)
  ) u_v_axis (
    .clk_i(clk_in), .rst_ni(rst_n), .en_i(v_en_s),
    .cnt_o(v_cnt_s), .tc_o(v_tc_unused_s), .zero_o(v_zero_s),
    .active_o(v_act_s), .sync_o(v_sync_s)
  );

  assign fetch_req = h_act_s & v_act_s;
  assign fetch_x   = h_cnt_s[9:0];
  assign fetch_y   = v_cnt_s;

  // Output decode of the live counters; everything holds while disabled.
  always_comb begin
    if (en) begin
      hsync_d       = h_sync_s ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_sync_s ? SYNC_POL : ~SYNC_POL;
      de_d          = h_act_s & v_act_s;
      pix_x_d       = h_cnt_s;
      pix_y_d       = v_cnt_s;
      frame_start_d = h_zero_s & v_zero_s;
      line_start_d  = h_zero_s;
    end else begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      frame_start_d = frame_start_q;
      line_start_d  = line_start_q;
    end
  end

  // Output registers; reset forces syncs to their inactive level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      pix_x_q       <= {HW{1'b0}};
      pix_y_q       <= {VW{1'b0}};
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_800x600.sv
// Scoreboard bench for vga_timing_800x600 with a shortened vertical raster
// so full frames, an enable freeze and a mid-frame reset fit a short run.
`timescale 1ns/1ps
module tb_vga_timing_800x600;

  localparam int HV = 800, HFP = 40, HS = 128, HBP = 88;
  localparam int VV = 20,  VFP = 1,  VS = 4,   VBP = 3;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        hsync, vsync, de, frame_start, line_start, fetch_req;
  logic [10:0] pix_x;
  logic [9:0]  pix_y, fetch_x, fetch_y;

  vga_timing_800x600 #(
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_start(line_start),
    .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hs, vs, de, fs, ls, freq;
    int   x, y, fx, fy;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   k;              // enabled clock edges since reset release
  int   interval_done = 0;
  logic [19:0] ram_q;

  // Pixel source content as a function of coordinates.
  function automatic logic [19:0] pix_f(input int x, input int y);
    return 20'((x * 37) ^ (y * 1021) ^ 20'h5A5A5);
  endfunction

  // Expected DUT state after k enabled edges: outputs show raster
  // position k-1, the fetch address shows position k.
  function automatic exp_t expect_at(input int kk);
    exp_t e;
    int c, p;
    c = kk % FR;
    e.fx = c % HT;
    e.fy = c / HT;
    e.freq = (e.fx < HV) && (e.fy < VV);
    if (kk == 0) begin
      e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0; e.fs = 1'b0; e.ls = 1'b0;
      e.x = 0; e.y = 0;
    end else begin
      p = (kk - 1) % FR;
      e.x  = p % HT;
      e.y  = p / HT;
      e.de = (e.x < HV) && (e.y < VV);
      e.hs = (e.x >= HV + HFP) && (e.x < HV + HFP + HS);
      e.vs = (e.y >= VV + VFP) && (e.y < VV + VFP + VS);
      e.ls = (e.x == 0);
      e.fs = (e.x == 0) && (e.y == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("hsync", 32'(hsync), 32'(e.hs));
    chk("vsync", 32'(vsync), 32'(e.vs));
    chk("de", 32'(de), 32'(e.de));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("line_start", 32'(line_start), 32'(e.ls));
    chk("pix_x", 32'(pix_x), 32'(e.x));
    chk("pix_y", 32'(pix_y), 32'(e.y));
    chk("fetch_req", 32'(fetch_req), 32'(e.freq));
    chk("fetch_x", 32'(fetch_x), 32'(e.fx % 1024));
    chk("fetch_y", 32'(fetch_y), 32'(e.fy));
    if (rst_n && e.de) chk("fetch_data", 32'(ram_q), 32'(pix_f(e.x, e.y)));
  endtask

  // One-cycle synchronous RAM read, stalled together with the raster.
  always @(posedge clk) begin
    if (en) ram_q <= pix_f(int'(fetch_x), int'(fetch_y));
  end

  // Monitor: pop one expectation per edge and compare just after it.
  initial begin : monitor
    exp_t e;
    logic en_s;
    int   cyc;
    int   fs_cyc;
    int   have_fs;
    cyc = 0; fs_cyc = 0; have_fs = 0;
    forever begin
      @(posedge clk);
      en_s = en;
      cyc++;
      #1;
      if (!rst_n) begin
        cmp_all(expect_at(0));
      end else if (q.size() > 0) begin
        e = q.pop_front();
        cmp_all(e);
        if (en_s && frame_start) begin
          if (have_fs != 0 && interval_done == 0) begin
            chk("frame_interval", 32'(cyc - fs_cyc), 32'(FR + 10));
            interval_done = 1;
          end
          fs_cyc = cyc;
          have_fs = 1;
        end
      end
    end
  end

  task automatic step(input logic e);
    @(negedge clk);
    en = e;
    if (e) k++;
    q.push_back(expect_at(k));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    k = 1;
    q.push_back(expect_at(1));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver: stimulus plus a few directed spot checks.
  initial begin : driver
    int k_target;
    rst_n = 1'b0;
    en = 1'b0;
    k = 0;
    repeat (3) @(posedge clk);
    release_reset();
    @(posedge clk); #2;
    chk("first_frame_start", 32'(frame_start), 32'd1);
    chk("first_line_start", 32'(line_start), 32'd1);
    chk("first_de", 32'(de), 32'd1);

    // Frame 1: free-running, with a 10-cycle freeze at (500, 10).
    while (k < 10 * HT + 500 + 1) step(1'b1);
    repeat (10) step(1'b0);
    step(1'b1);
    @(posedge clk); #2;
    chk("resume_pix_x", 32'(pix_x), 32'd501);
    chk("resume_pix_y", 32'(pix_y), 32'd10);
    while (k < FR + 2 * HT) step(1'b1);

    // Frame 2: random enable gaps until output reaches a vsync line.
    k_target = FR + (VV + VFP + 1) * HT + 300 + 1;
    for (int i = 0; i < 2 * FR && k < k_target; i++)
      step($urandom_range(0, 31) != 0);
    chk("reach_vsync_line", 32'(k), 32'(k_target));

    @(posedge clk); #2;
    chk("pre_reset_vsync", 32'(vsync), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_vsync_drop", 32'(vsync), 32'd0);
    chk("async_pix_y", 32'(pix_y), 32'd0);
    q.delete();
    k = 0;
    repeat (3) @(posedge clk);
    release_reset();
    @(posedge clk); #2;
    chk("restart_frame_start", 32'(frame_start), 32'd1);
    chk("restart_pix_x", 32'(pix_x), 32'd0);

    repeat (2 * HT) step($urandom_range(0, 7) != 0);
    @(posedge clk); #2;
    chk("frame_interval_seen", 32'(interval_done), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_800x600.md
Name: vga_timing_800x600

Overview:
- Raster timing generator for SVGA 800x600 @ 60 Hz.
- Runs on the 40 MHz pixel clock produced by clk_40MHz.
- Produces registered hsync/vsync/data-enable, current pixel coordinates, frame/line strobes, and a one-cycle-early fetch address for the downstream pixel source (frame buffer / pattern ROM).

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync (1 = positive, the SVGA standard)

Ports:
- clk_in  in  1  40 MHz pixel clock (clk_out of clk_40MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low freezes all state
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- de  out  1  data enable, high in the visible region, registered
- pix_x  out  11  horizontal count of the current output cycle (0..1055), registered
- pix_y  out  10  vertical count of the current output cycle (0..627), registered
- frame_start  out  1  one-cycle pulse when pix_x=0 and pix_y=0
- line_start  out  1  one-cycle pulse when pix_x=0
- fetch_req  out  1  combinational; high when the internal counter is in the visible region
- fetch_x  out  10  internal h counter, low bits, valid when fetch_req=1
- fetch_y  out  10  internal v counter, valid when fetch_req=1

Behaviour:
- Derived totals: H_TOTAL = 1056, V_TOTAL = 628. Frame length is 663168 clocks.
- Internal counters h_cnt and v_cnt reset to 0.
- Counter update, on each clk_in edge with en=1:
  - if h_cnt = H_TOTAL-1: h_cnt goes to 0 and v_cnt advances (wraps V_TOTAL-1 → 0);
  - otherwise h_cnt increments.
- en=0: counters and all registered outputs hold their value. fetch_req still reflects the frozen counters.
- Registered outputs sample the counter state of the previous cycle, so outputs lag the fetch address by exactly 1 clock. This matches a 1-cycle synchronous RAM read.
- de = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE).
- hsync = SYNC_POL when h_cnt is in [840, 967]; otherwise ~SYNC_POL.
- vsync = SYNC_POL when v_cnt is in [601, 604]; otherwise ~SYNC_POL. vsync changes at line boundaries only, aligned with h_cnt = 0.
- pix_x/pix_y are registered copies of h_cnt/v_cnt.
- frame_start and line_start are decoded from the counters and registered with the other outputs.
- fetch_req = de condition evaluated on the live counters. fetch_x/fetch_y are the live counters.
- Reset values (asynchronous, immediate on rst_n low):
  - hsync = vsync = ~SYNC_POL;
  - de = 0, pix_x = 0, pix_y = 0, frame_start = 0, line_start = 0;
  - counters = 0, so fetch_req = 1 with fetch_x/fetch_y = 0 during reset.
- First edge after rst_n rises with en=1: de=1, pix_x=0, pix_y=0, frame_start=1, line_start=1.
- Reset mid-frame: immediate return to the reset state; the frame restarts at (0,0). No partial-sync glitch beyond the forced inactive level.
- en toggling: no pulse is repeated or lost. A pulse whose cycle was reached while en=0 is held on the outputs until en returns.
- Parameter rule: porch/sync values must keep totals within the counter widths. Widths come from $clog2 of the totals.

Decomposition:
- Package vga_timing_pkg holds:
  - timing constants (visible, porch, sync, totals);
  - derived sync start/end constants;
  - H_CNT_W = 11 and V_CNT_W = 10.
- One sub-module: vga_axis_counter, instanced for horizontal and vertical.
  - Generic wrapping counter with enable, terminal-count output, and an active-window/sync-window decode.
  - The vertical instance is enabled by horizontal terminal count AND en.

Test Plan:
- Reset: rst_n low → hsync=vsync=0 (SYNC_POL=1), de=0, pix_x=pix_y=0. Release with en=1 → first edge gives de=1, frame_start=1, line_start=1.
- Line timing: count cycles from line_start.
  - de high for 800 clocks, then low 256.
  - hsync rises at pix_x=840 and falls at pix_x=968.
  - next line_start after 1056 clocks.
- Frame timing:
  - vsync high exactly on lines 601–604 (4 × 1056 clocks);
  - de low on lines 600–627;
  - frame_start recurs every 663168 clocks at pix_x=0, pix_y=0.
- Fetch alignment: model a 1-cycle RAM returning f(fetch_x, fetch_y). Data arriving with de=1 must equal f(pix_x, pix_y) for every visible pixel.
- Enable freeze: drop en for 10 cycles at pix_x=500, pix_y=300 → all outputs constant; on resume the next edge gives pix_x=501, and the frame total is extended by exactly 10 clocks.
- Reset mid-frame: assert rst_n at pix_y=602 (vsync high) → vsync drops asynchronously to 0; after release, frame_start fires on the first edge.
